// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: sequential instruction prefetch queue between the I-cache and the fetch stage
//   redirect/redirect_addr : flush queue and restart fetch at a new word-aligned PC
//   cache_req/cache_addr   : one-word request at the current fetch PC
//   cache_ready/data/err   : response for cache_addr while cache_req is high
//   cache_flush            : registered pulse the cycle after a redirect
//   inst_valid/addr/data/err, inst_take : in-order head of the queue to the core
module fetch_prefetch_buffer #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        cache_req,
    output logic [31:0] cache_addr,
    output logic        cache_flush,
    input  logic        cache_ready,
    input  logic [31:0] cache_data,
    input  logic        cache_err,
    output logic        inst_valid,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_err,
    input  logic        inst_take
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {FETCH, HALT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          run_q, run_d, flush_q, flush_d;
    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic          err_q  [DEPTH];
    logic          err_d  [DEPTH];
    logic          push, pop;

    // run_q holds requests off for the first cycle after reset release
    assign cache_req   = run_q && state_q == FETCH && count_q < FULL;
    assign cache_addr  = fetch_pc_q;
    assign cache_flush = flush_q;
    assign inst_valid  = count_q != '0;
    assign inst_addr   = addr_q[rd_ptr_q];
    assign inst_data   = data_q[rd_ptr_q];
    assign inst_err    = err_q[rd_ptr_q];
    assign push        = cache_req && cache_ready && !redirect;
    assign pop         = inst_take && inst_valid && !redirect;

    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
        run_d      = 1'b1;
        flush_d    = redirect;
        state_d    = redirect ? FETCH : (push && cache_err) ? HALT : state_q;
        fetch_pc_d = redirect ? {redirect_addr[31:2], 2'b00} : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
        rd_ptr_d   = redirect ? wr_ptr_q : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
        if (push) begin
            addr_d[wr_ptr_q] = fetch_pc_q;
            data_d[wr_ptr_q] = cache_data;
            err_d[wr_ptr_q]  = cache_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_ADDR;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            run_q      <= 1'b0;
            flush_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            run_q      <= run_d;
            flush_q    <= flush_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: directed and randomised checks of fetch_prefetch_buffer against a queue model
module tb_fetch_prefetch_buffer;
    localparam logic [31:0] XK = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        cache_req, cache_flush, cache_ready = 1'b0, cache_err;
    logic [31:0] cache_addr, cache_data;
    logic        inst_valid, inst_err, inst_take = 1'b0;
    logic [31:0] inst_addr, inst_data;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    logic        mrun, mhalt, mflush, mreq, me;

    assign cache_data = cache_addr ^ XK;
    assign cache_err  = err_en && cache_addr == err_addr;

    fetch_prefetch_buffer #(.DEPTH(4), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
        .cache_req(cache_req), .cache_addr(cache_addr), .cache_flush(cache_flush),
        .cache_ready(cache_ready), .cache_data(cache_data), .cache_err(cache_err),
        .inst_valid(inst_valid), .inst_addr(inst_addr), .inst_data(inst_data),
        .inst_err(inst_err), .inst_take(inst_take)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Queue model: request when started, not halted and fewer than 4 entries held
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mpc    = 32'h0;
            mrun   = 1'b0;
            mhalt  = 1'b0;
            mflush = 1'b0;
        end else begin
            mreq = mrun && !mhalt && mq.size() < 4;
            if (redirect) begin
                mq.delete();
                mpc    = {redirect_addr[31:2], 2'b00};
                mhalt  = 1'b0;
                mflush = 1'b1;
            end else begin
                mflush = 1'b0;
                if (inst_take && mq.size() > 0) void'(mq.pop_front());
                if (mreq && cache_ready) begin
                    me = err_en && mpc == err_addr;
                    mq.push_back('{a: mpc, d: mpc ^ XK, e: me});
                    mpc = mpc + 32'd4;
                    if (me) mhalt = 1'b1;
                end
            end
            mrun = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req", cache_req, 0);
            chk("rst_flush", cache_flush, 0);
            chk("rst_valid", inst_valid, 0);
            chk("rst_iaddr", inst_addr, 0);
            chk("rst_idata", inst_data, 0);
            chk("rst_ierr", inst_err, 0);
        end else begin
            chk("m_req", cache_req, 32'(mrun && !mhalt && mq.size() < 4));
            chk("m_caddr", cache_addr, mpc);
            chk("m_flush", cache_flush, 32'(mflush));
            chk("m_valid", inst_valid, 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("m_iaddr", inst_addr, mq[0].a);
                chk("m_idata", inst_data, mq[0].d);
                chk("m_ierr", inst_err, 32'(mq[0].e));
            end
        end
    end

    initial begin
        // 1: streaming with take every cycle
        cache_ready = 1'b1;
        inst_take = 1'b1;
        do_reset();
        chk("t1_req_held", cache_req, 0);
        tick();
        chk("t1_req_rise", cache_req, 1);
        chk("t1_no_valid", inst_valid, 0);
        tick();
        chk("t1_first_valid", inst_valid, 1);
        chk("t1_addr0", inst_addr, 32'h0);
        chk("t1_data0", inst_data, 32'hA5A5A5A5);
        tick();
        chk("t1_addr4", inst_addr, 32'h4);
        tick();
        chk("t1_addr8", inst_addr, 32'h8);
        // 2: fill to full, then one take reopens requests
        inst_take = 1'b0;
        do_reset();
        tick();
        repeat (4) tick();
        chk("t2_full_req", cache_req, 0);
        chk("t2_full_addr", cache_addr, 32'h10);
        chk("t2_head", inst_addr, 32'h0);
        inst_take = 1'b1;
        tick();
        inst_take = 1'b0;
        chk("t2_req_back", cache_req, 1);
        chk("t2_head4", inst_addr, 32'h4);
        tick();
        chk("t2_refull", cache_req, 0);
        chk("t2_addr14", cache_addr, 32'h14);
        // 3: redirect with concurrent response and take
        do_reset();
        tick();
        repeat (3) tick();
        redirect = 1'b1;
        redirect_addr = 32'h203;
        inst_take = 1'b1;
        tick();
        redirect = 1'b0;
        chk("t3_valid0", inst_valid, 0);
        chk("t3_flush", cache_flush, 1);
        chk("t3_addr", cache_addr, 32'h200);
        chk("t3_req", cache_req, 1);
        inst_take = 1'b0;
        tick();
        chk("t3_first", inst_addr, 32'h200);
        chk("t3_flush_gone", cache_flush, 0);
        // 4: bus error halts fetch until a redirect
        err_en = 1'b1;
        err_addr = 32'h8;
        do_reset();
        tick();
        repeat (3) tick();
        chk("t4_halt_req", cache_req, 0);
        inst_take = 1'b1;
        repeat (2) tick();
        inst_take = 1'b0;
        chk("t4_err_addr", inst_addr, 32'h8);
        chk("t4_err", inst_err, 1);
        tick();
        chk("t4_still_halt", cache_req, 0);
        redirect = 1'b1;
        redirect_addr = 32'h40;
        tick();
        redirect = 1'b0;
        err_en = 1'b0;
        chk("t4_resume_req", cache_req, 1);
        chk("t4_resume_addr", cache_addr, 32'h40);
        tick();
        chk("t4_first", inst_addr, 32'h40);
        chk("t4_noerr", inst_err, 0);
        // 5: PC wraps past the top of the address space
        redirect = 1'b1;
        redirect_addr = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        chk("t5_e0", inst_addr, 32'hFFFF_FFF8);
        inst_take = 1'b1;
        tick();
        chk("t5_e1", inst_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_e2", inst_addr, 32'h0);
        inst_take = 1'b0;
        // 6: asynchronous reset with entries queued
        do_reset();
        tick();
        repeat (2) tick();
        chk("t6_pre", inst_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_valid", inst_valid, 0);
        chk("t6_req", cache_req, 0);
        tick();
        rst = 1'b0;
        chk("t6_addr", cache_addr, 32'h0);
        tick();
        chk("t6_req_back", cache_req, 1);
        tick();
        chk("t6_first", inst_addr, 32'h0);
        // random traffic, model checks every cycle
        err_en = 1'b1;
        err_addr = 32'h24;
        for (int i = 0; i < 400; i++) begin
            cache_ready = 1'($urandom_range(0, 1));
            inst_take = 1'($urandom_range(0, 1));
            redirect = $urandom_range(0, 15) == 0;
            redirect_addr = 32'($urandom_range(0, 63));
            tick();
        end
        redirect = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
